// File: rtl/apb_bridge_pkg.sv
// Shared types and field positions for the APB async bridge command/response paths.
// Command {pwrite, paddr, pwdata}; response {err, pwrite, rdata}.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int CMD_W = 65;
    localparam int RSP_W = 34;

    localparam int CMD_PWRITE_BIT = 64;
    localparam int CMD_PADDR_HI   = 63;
    localparam int CMD_PADDR_LO   = 32;
    localparam int CMD_PWDATA_HI  = 31;
    localparam int CMD_PWDATA_LO  = 0;

    localparam int RSP_ERR_BIT    = 33;
    localparam int RSP_PWRITE_BIT = 32;
    localparam int RSP_RDATA_HI   = 31;
    localparam int RSP_RDATA_LO   = 0;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_rsp_fifo.sv
// Synchronous response FIFO, extra pointer bit distinguishes full from empty; count feeds the credit rule.
// Zero-latency head (rdata is 0 when empty); simultaneous push and pop are both honoured.
module apb_rsp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (!full) else $error("apb_rsp_fifo: push while full");
        end
    end
`endif

endmodule

// File: rtl/apb_master_seq.sv
// APB master sequencer: pops commands, runs SETUP/ACCESS, queues one response per transfer.
// Response 1 cycle after pready; credit-gated pops; APB_SEQ_TIMEOUT_EN adds a forced ACCESS timeout.
module apb_master_seq
    import apb_bridge_pkg::*;
#(
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_b,
    input  logic              rst_b,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_ready,
    output logic [31:0]       paddr_b,
    output logic [31:0]       pwdata_b,
    output logic              pwrite_b,
    output logic              psel_b,
    output logic              penable_b,
    input  logic [31:0]       prdata_b,
    input  logic              pready_b,
    input  logic              pslverr_b,
    output logic              rsp_valid,
    output logic [RSP_W-1:0]  rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_IDLE = CW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] CREDIT_B2B  = CW'(RSP_DEPTH - 2);

    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RSP_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit wait counter");
    end

    apb_state_e       state;
    apb_state_e       state_nxt;
    logic [31:0]      paddr_q;
    logic [31:0]      pwdata_q;
    logic             pwrite_q;
    logic             accept;
    logic             push;
    logic [RSP_W-1:0] push_data;
    logic [CW-1:0]    rsp_cnt;
    logic             rsp_empty;
    logic             timed_out;

`ifdef APB_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt;

    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS && !pready_b) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // A real pready in the same cycle wins over the forced completion.
    assign timed_out = (state == ST_ACCESS) && !pready_b && (wait_cnt == TIMEOUT_LIM);
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        push      = 1'b0;
        push_data = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && (rsp_cnt <= CREDIT_IDLE)) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_b || timed_out) begin
                    push                      = 1'b1;
                    push_data[RSP_PWRITE_BIT] = pwrite_q;
                    if (timed_out) begin
                        push_data[RSP_ERR_BIT]                = 1'b1;
                        push_data[RSP_RDATA_HI:RSP_RDATA_LO] = TIMEOUT_RDATA;
                    end else begin
                        push_data[RSP_ERR_BIT]                = pslverr_b;
                        push_data[RSP_RDATA_HI:RSP_RDATA_LO] = pwrite_q ? 32'h0 : prdata_b;
                    end
                    // The push above occupies a slot this cycle, hence the tighter credit.
                    if (cmd_valid && (rsp_cnt <= CREDIT_B2B)) begin
                        accept    = 1'b1;
                        state_nxt = ST_SETUP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            state    <= ST_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pwrite_q <= cmd_data[CMD_PWRITE_BIT];
                paddr_q  <= cmd_data[CMD_PADDR_HI:CMD_PADDR_LO];
                pwdata_q <= cmd_data[CMD_PWDATA_HI:CMD_PWDATA_LO];
            end
        end
    end

    // Nothing is consumed from the command FIFO while held in reset.
    assign cmd_ready = accept && !rst_b;
    assign paddr_b   = paddr_q;
    assign pwdata_b  = pwdata_q;
    assign pwrite_b  = pwrite_q;
    assign psel_b    = (state != ST_IDLE);
    assign penable_b = (state == ST_ACCESS);
    assign busy      = psel_b;
    assign rsp_valid = !rsp_empty;

    apb_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk_b),
        .rst   (rst_b),
        .push  (push),
        .wdata (push_data),
        .pop   (rsp_ready),
        .rdata (rsp_data),
        .empty (rsp_empty),
        .count (rsp_cnt)
    );

endmodule

// File: tb/tb_apb_master_seq.sv
// Directed bench for apb_master_seq: command queue source, APB slave with programmable wait states.
module tb_apb_master_seq;

    logic        clk_b = 1'b0;
    logic        rst_b = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [64:0] cmd_data = '0;
    logic        cmd_ready;
    logic [31:0] paddr_b;
    logic [31:0] pwdata_b;
    logic        pwrite_b;
    logic        psel_b;
    logic        penable_b;
    logic [31:0] prdata_b = '0;
    logic        pready_b = 1'b0;
    logic        pslverr_b = 1'b0;
    logic        rsp_valid;
    logic [33:0] rsp_data;
    logic        rsp_ready = 1'b0;
    logic        busy;

    apb_master_seq dut (
        .clk_b     (clk_b),
        .rst_b     (rst_b),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .paddr_b   (paddr_b),
        .pwdata_b  (pwdata_b),
        .pwrite_b  (pwrite_b),
        .psel_b    (psel_b),
        .penable_b (penable_b),
        .prdata_b  (prdata_b),
        .pready_b  (pready_b),
        .pslverr_b (pslverr_b),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk_b = ~clk_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [64:0] cmdq[$];
    logic [33:0] rspq[$];
    int          pops = 0;
    int          wait_states = 0;
    int          acc_cnt = 0;
    logic        err_val = 1'b0;
    logic [31:0] rd_val = '0;
    bit          fire;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshakes sampled at the edge; stimulus updated just after it.
    always @(posedge clk_b) begin
        fire = cmd_valid && cmd_ready;
        if (!rst_b && rsp_valid && rsp_ready) rspq.push_back(rsp_data);
        #1;
        if (fire) begin
            void'(cmdq.pop_front());
            pops++;
        end
        if (cmdq.size() > 0) begin
            cmd_valid = 1'b1;
            cmd_data  = cmdq[0];
        end else begin
            cmd_valid = 1'b0;
            cmd_data  = '0;
        end
        if (psel_b && penable_b) begin
            if (acc_cnt == wait_states) begin
                pready_b  = 1'b1;
                pslverr_b = err_val;
                prdata_b  = rd_val ^ {paddr_b[7:0], 24'h0};
            end else begin
                pready_b  = 1'b0;
                pslverr_b = 1'b0;
                prdata_b  = 32'hFFFF_FFFF;
            end
            acc_cnt++;
        end else begin
            pready_b  = 1'b0;
            pslverr_b = 1'b0;
            prdata_b  = 32'hFFFF_FFFF;
            acc_cnt   = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_b);
    endtask

    logic [33:0] exp_b2b [4] = '{34'h0_0000_00A0, 34'h1_0000_0000, 34'h0_0800_00A0, 34'h1_0000_0000};
    logic [33:0] exp_bp  [6] = '{34'h0_0000_0055, 34'h0_0400_0055, 34'h0_0800_0055,
                                 34'h0_0C00_0055, 34'h0_1000_0055, 34'h0_1400_0055};
    int pops_base;

    initial begin
        // Reset state
        cyc(3);
        check("rst_psel", psel_b, 0);
        check("rst_penable", penable_b, 0);
        check("rst_paddr", paddr_b, 0);
        check("rst_pwdata", pwdata_b, 0);
        check("rst_pwrite", pwrite_b, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        rst_b = 1'b0;
        cyc(2);

        // Single write, zero wait states
        cmdq.push_back({1'b1, 32'h0000_1000, 32'hA5A5_0001});
        cyc(1);
        check("wr_n_cmd_ready", cmd_ready, 1);
        check("wr_n_psel", psel_b, 0);
        cyc(1);
        check("wr_setup_psel", psel_b, 1);
        check("wr_setup_penable", penable_b, 0);
        check("wr_setup_paddr", paddr_b, 32'h1000);
        check("wr_setup_pwdata", pwdata_b, 32'hA5A5_0001);
        check("wr_setup_pwrite", pwrite_b, 1);
        check("wr_setup_cmd_ready", cmd_ready, 0);
        cyc(1);
        check("wr_access_penable", penable_b, 1);
        check("wr_access_rsp_valid", rsp_valid, 0);
        cyc(1);
        check("wr_n3_rsp_valid", rsp_valid, 1);
        check("wr_n3_rsp_data", rsp_data, 34'h1_0000_0000);
        check("wr_n3_psel", psel_b, 0);
        check("wr_idle_paddr_hold", paddr_b, 32'h1000);
        rsp_ready = 1'b1;
        cyc(1);
        rsp_ready = 1'b0;
        check("wr_popped_valid", rsp_valid, 0);
        check("wr_rspq_size", rspq.size(), 1);
        check("wr_rspq_data", rspq[0], 34'h1_0000_0000);

        // Read with 3 wait states
        rspq.delete();
        wait_states = 3;
        rd_val = 32'h1234_5678;
        cmdq.push_back({1'b0, 32'h0000_2000, 32'h0});
        cyc(1);
        check("rd_cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check($sformatf("rd_psel_%0d", k), psel_b, 1);
            check($sformatf("rd_penable_%0d", k), penable_b, (k == 0) ? 0 : 1);
            check($sformatf("rd_paddr_%0d", k), paddr_b, 32'h2000);
            check($sformatf("rd_rsp_valid_%0d", k), rsp_valid, 0);
        end
        cyc(1);
        check("rd_done_psel", psel_b, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_data, 34'h0_1234_5678);
        rsp_ready = 1'b1;
        cyc(1);

        // Back-to-back: four queued commands, alternating read/write
        rspq.delete();
        wait_states = 0;
        rd_val = 32'h0000_00A0;
        for (int i = 0; i < 4; i++)
            cmdq.push_back({i[0], 32'h3000 + 32'(4 * i), 32'h0000_00B0 + 32'(i)});
        cyc(1);
        check("b2b_first_ready", cmd_ready, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            check($sformatf("b2b_psel_%0d", k), psel_b, 1);
            check($sformatf("b2b_penable_%0d", k), penable_b, k % 2);
        end
        cyc(1);
        check("b2b_end_psel", psel_b, 0);
        cyc(3);
        check("b2b_rsp_count", rspq.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_rsp_%0d", i), rspq[i], exp_b2b[i]);

        // Backpressure: six commands, response FIFO held full
        rspq.delete();
        rsp_ready = 1'b0;
        rd_val = 32'h0000_0055;
        pops_base = pops;
        for (int i = 0; i < 6; i++)
            cmdq.push_back({1'b0, 32'h4000 + 32'(4 * i), 32'h0});
        cyc(20);
        check("bp_pops_stalled", pops - pops_base, 4);
        check("bp_cmd_ready_low", cmd_ready, 0);
        check("bp_psel_low", psel_b, 0);
        check("bp_cmd_pending", cmd_valid, 1);
        check("bp_head", rsp_data, exp_bp[0]);
        rsp_ready = 1'b1;
        cyc(30);
        check("bp_pops_total", pops - pops_base, 6);
        check("bp_rsp_count", rspq.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("bp_rsp_%0d", i), rspq[i], exp_bp[i]);

        // Slave error on a write and on a read
        rspq.delete();
        err_val = 1'b1;
        wait_states = 1;
        rd_val = 32'h0000_0077;
        cmdq.push_back({1'b1, 32'h5000, 32'h1});
        cmdq.push_back({1'b0, 32'h5004, 32'h0});
        cyc(12);
        err_val = 1'b0;
        check("err_rsp_count", rspq.size(), 2);
        check("err_wr", rspq[0], 34'h3_0000_0000);
        check("err_rd", rspq[1], 34'h2_0400_0077);

`ifdef APB_SEQ_TIMEOUT_EN
        // Forced completion after 256 waiting ACCESS cycles
        rspq.delete();
        rsp_ready = 1'b0;
        wait_states = 100000;
        cmdq.push_back({1'b0, 32'h6000, 32'h0});
        cyc(1);
        check("to_cmd_ready", cmd_ready, 1);
        cyc(258);
        check("to_last_access", penable_b, 1);
        check("to_not_yet", rsp_valid, 0);
        cyc(1);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_data", rsp_data, 34'h2_DEAD_BEEF);
        check("to_psel", psel_b, 0);
        rsp_ready = 1'b1;
        cyc(1);
`endif

        // Reset mid-ACCESS with a response already queued
        rspq.delete();
        rsp_ready = 1'b0;
        wait_states = 0;
        cmdq.push_back({1'b1, 32'h7000, 32'h77});
        cyc(6);
        check("mr_queued", rsp_valid, 1);
        wait_states = 5;
        cmdq.push_back({1'b0, 32'h7004, 32'h0});
        cyc(4);
        check("mr_in_access", penable_b, 1);
        rst_b = 1'b1;
        cyc(1);
        rst_b = 1'b0;
        check("mr_psel", psel_b, 0);
        check("mr_penable", penable_b, 0);
        check("mr_paddr", paddr_b, 0);
        check("mr_pwdata", pwdata_b, 0);
        check("mr_pwrite", pwrite_b, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_rsp_data", rsp_data, 0);
        check("mr_busy", busy, 0);
        check("mr_cmd_ready", cmd_ready, 0);
        wait_states = 0;
        rd_val = 32'h0000_0099;
        rsp_ready = 1'b1;
        cmdq.push_back({1'b0, 32'h7008, 32'h0});
        cyc(8);
        check("mr_after_count", rspq.size(), 1);
        check("mr_after_rsp", rspq[0], 34'h0_0800_0099);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_seq.md
# apb_master_seq

Clock-B-domain APB master sequencer sitting directly downstream of the APB async bridge's command FIFO. Pops one packed command `{pwrite, paddr, pwdata}` at a time and drives a protocol-correct APB SETUP/ACCESS sequence to the B-side slave. Waits for `pready_b`, captures read data and error status, and pushes one response per transfer into a local response FIFO for the return path toward clock domain A.

## Interface
Parameters:
- `RSP_DEPTH`, 4: response FIFO entries, a power of two and ≥2.
- `TIMEOUT_CYCLES`, 256: ACCESS-phase wait limit. Only used with `APB_SEQ_TIMEOUT_EN`.

Ports:
- `clk_b`  in  1  single clock, B domain.
- `rst_b`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command available (FIFO not empty).
- `cmd_data`  in  65  `{pwrite[64], paddr[63:32], pwdata[31:0]}`.
- `cmd_ready`  out  1  one-cycle pop strobe; the command is consumed when `cmd_valid & cmd_ready`.
- `paddr_b`, `pwdata_b`  out  32 each  APB address and write data.
- `pwrite_b`, `psel_b`, `penable_b`  out  1 each  APB controls.
- `prdata_b`  in  32  APB read data.
- `pready_b`, `pslverr_b`  in  1 each  APB completion and error.
- `rsp_valid`  out  1  response FIFO not empty.
- `rsp_data`  out  34  `{err[33], pwrite[32], rdata[31:0]}`, head of the FIFO.
- `rsp_ready`  in  1  response pop when `rsp_valid & rsp_ready`.
- `busy`  out  1  high in SETUP or ACCESS.

## Operation
FSM states: IDLE, SETUP, ACCESS.
- **Credit rule:** the response FIFO count is `rsp_cnt`. A pop in the same cycle is not credited.
  - Accept in IDLE when `rsp_cnt ≤ RSP_DEPTH-1`.
  - Accept at ACCESS completion when `rsp_cnt ≤ RSP_DEPTH-2`.
- **IDLE:** `psel_b=0`, `penable_b=0`.
  - If `cmd_valid` and credit are available: assert `cmd_ready` combinationally, latch the command into the address/data/write registers, and go to SETUP.
- **SETUP:** `psel_b=1`, `penable_b=0`. Always go to ACCESS next cycle.
- **ACCESS:** `psel_b=1`, `penable_b=1`. Hold until `pready_b=1`.
  - On completion, push `{pslverr_b, pwrite_b, pwrite_b ? 32'h0 : prdata_b}`.
  - Then, if `cmd_valid` and credit are available: pop and latch the next command and go to SETUP. `psel_b` stays high (back-to-back).
  - Otherwise go to IDLE.
- `paddr_b`, `pwdata_b`, `pwrite_b` are stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE.
- At most one transfer is in flight, and every popped command yields exactly one response, in order.
- Response FIFO:
  - A push and a pop in the same cycle at any count are both honoured.
  - The credit rule makes a push while full impossible; an assertion checks this.

## Timing
- **Reset values:** every output is 0, FSM in IDLE, response FIFO empty. `rsp_data` is 0.
- **Reset mid-transfer:** abort immediately and drop `psel_b` on the cycle after reset is sampled. The in-flight command and all queued responses are discarded.
- **Latency:** `cmd_valid` seen in IDLE at cycle N.
  - SETUP at N+1, ACCESS at N+2.
  - With `pready_b=1` at N+2, `rsp_valid` rises at N+3.
  - Each wait-state cycle adds 1.
- **Throughput:** 2 cycles per transfer back-to-back (SETUP, ACCESS, SETUP, …).
- `cmd_ready` is only ever high in IDLE or on an ACCESS cycle with `pready_b=1`. It never pulses twice for one transfer.
- `pready_b` and `pslverr_b` are ignored outside ACCESS.

## Configuration
`APB_SEQ_TIMEOUT_EN`
- **Defined:** an 8–16-bit wait counter clears on entry to ACCESS and increments on every ACCESS cycle with `pready_b=0`.
  - When it reaches `TIMEOUT_CYCLES`, the transfer is forced to complete.
  - The response pushed is `err=1`, `rdata=32'hDEAD_BEEF`, `pwrite` is the latched value.
  - Next-state selection is the same as a normal completion.
- **Undefined:** ACCESS waits indefinitely. `err` comes only from `pslverr_b`. No counter logic is synthesised.

## Structure
- **Shared package `apb_bridge_pkg`:**
  - FSM state enum.
  - `CMD_W=65`, `RSP_W=34`, and the command/response field bit positions.
  - `TIMEOUT_RDATA=32'hDEAD_BEEF`.
- **Sub-module `apb_rsp_fifo`:** synchronous FIFO, width `RSP_W`, depth `RSP_DEPTH`.
  - Pointers are one bit wider than the address.
  - Exports its count for the credit rule.

## Test plan
- **Single write:** `cmd=(1, 0x1000, 0xA5A5_0001)`, `pready_b` tied 1.
  - SETUP then ACCESS at N+1/N+2.
  - `rsp_data=0x1_0000_0000` with err=0, write=1, rdata=0, valid at N+3.
- **Read with 3 wait states:** `prdata_b=0x1234_5678` when `pready_b` rises.
  - `paddr_b` is stable for all 5 APB cycles.
  - `rsp_data={0,0,0x1234_5678}`.
- **Back-to-back:** 4 queued commands with `rsp_ready=1`.
  - `psel_b` stays high for 8 cycles; `penable_b` toggles 0/1.
  - 4 in-order responses.
- **Backpressure:** `rsp_ready=0` with 6 commands queued (`RSP_DEPTH=4`).
  - Exactly 4 pops, then `cmd_ready` stays 0.
  - Releasing `rsp_ready` resumes transfers.
- **Error and timeout:**
  - `pslverr_b=1` at completion gives err=1.
  - With `APB_SEQ_TIMEOUT_EN`, holding `pready_b=0` gives completion after 256 ACCESS wait cycles with rdata `0xDEAD_BEEF`.
- **Reset mid-ACCESS:** assert `rst_b` for 1 cycle. All outputs return to 0 and the response FIFO is empty.
